mem_access_ctrl: RTL and testbench

Initiator-side memory access controller for the ARM pipeline's MEM stage. It takes the stage's read/write enables, ALU-computed byte address and store value, and translates them into word-addressed transactions toward a data memory with a variable-latency request/acknowledge handshake. It holds the pipeline frozen until each access completes, returns load data, and flags misaligned, out-of-range and timed-out accesses.

---
 rtl/mem_access_ctrl.sv | 102 ++++++++++
 tb/tb_mem_access_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator: turns pipeline load/store enables into word-addressed
// req/ack memory transactions, freezing the pipeline until each completes.
module mem_access_ctrl #(
  parameter int BASE    = 1024,
  parameter int DEPTH   = 64,
  parameter int AW      = 6,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MEM_R_EN,
  input  logic          MEM_W_EN,
  input  logic [31:0]   ALU_Res,
  input  logic [31:0]   Val_Rm,
  output logic          freeze,
  output logic          ready,
  output logic [31:0]   data_mem,
  output logic          fault,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   off;
  logic          legal;
  logic          req;

  assign off    = ALU_Res - 32'(BASE);
  assign legal  = (ALU_Res >= 32'(BASE)) && (off[1:0] == 2'b00) && (off[31:2] < 30'(DEPTH));
  assign req    = MEM_R_EN | MEM_W_EN;
  assign freeze = req & ~ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ready     <= 1'b0;
      fault     <= 1'b0;
      data_mem  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (legal) begin
              // The strobe registers double as the transaction kind; write wins.
              mem_addr  <= off[AW+1:2];
              mem_wdata <= Val_Rm;
              mem_we    <= MEM_W_EN;
              mem_re    <= ~MEM_W_EN;
              cnt       <= '0;
              state     <= BUSY;
            end else begin
              fault    <= 1'b1;
              data_mem <= '0;
              ready    <= 1'b1;
              state    <= DONE;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            data_mem <= mem_re ? mem_rdata : 32'd0;
            fault    <= 1'b0;
            ready    <= 1'b1;
            mem_re   <= 1'b0;
            mem_we   <= 1'b0;
            state    <= DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // This ack-less cycle brings the count to TIMEOUT: abort.
            fault    <= 1'b1;
            data_mem <= '0;
            ready    <= 1'b1;
            mem_re   <= 1'b0;
            mem_we   <= 1'b0;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: inputs driven and outputs checked at the
// falling edge, one task per scenario.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] ALU_Res, Val_Rm;
  logic        freeze, ready, fault;
  logic [31:0] data_mem;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.BASE(1024), .DEPTH(64), .AW(6), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .freeze(freeze), .ready(ready),
    .data_mem(data_mem), .fault(fault), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs;
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; ALU_Res = 32'd1024;
    Val_Rm = 32'h5555_AAAA; mem_rdata = 32'h1111_2222; mem_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({ready, fault, mem_re, mem_we} !== 4'b0000 || data_mem !== 32'd0 ||
        mem_addr !== 6'd0 || mem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%0b flt=%0b re=%0b we=%0b d=%h a=%0d wd=%h exp all 0",
               ready, fault, mem_re, mem_we, data_mem, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 6'd0) begin
      errors++;
      $display("FAIL reset_release_busy got re=%0b we=%0b a=%0d exp re=1 we=0 a=0", mem_re, mem_we, mem_addr);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || fault !== 1'b0 || data_mem !== 32'h1111_2222) begin
      errors++;
      $display("FAIL reset_first_read got rdy=%0b flt=%0b d=%h exp 1 0 11112222", ready, fault, data_mem);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_store;
    MEM_W_EN = 1'b1; ALU_Res = 32'd1032; Val_Rm = 32'hDEAD_BEEF; mem_ack = 1'b1;
    #1;
    checks++;
    if (freeze !== 1'b1) begin errors++; $display("FAIL store_freeze_c0 got %0b exp 1", freeze); end
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 6'd2 || mem_wdata !== 32'hDEAD_BEEF ||
        freeze !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL store_busy got we=%0b re=%0b a=%0d wd=%h frz=%0b rdy=%0b exp 1 0 2 deadbeef 1 0",
               mem_we, mem_re, mem_addr, mem_wdata, freeze, ready);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || fault !== 1'b0 || data_mem !== 32'd0 || mem_we !== 1'b0 || freeze !== 1'b0) begin
      errors++;
      $display("FAIL store_done got rdy=%0b flt=%0b d=%h we=%0b frz=%0b exp 1 0 0 0 0",
               ready, fault, data_mem, mem_we, freeze);
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL store_ready_pulse got %0b exp 0", ready); end
  endtask

  task automatic test_load_delayed;
    int re_cycles = 0;
    MEM_R_EN = 1'b1; ALU_Res = 32'd1032; mem_rdata = 32'h1234_5678; mem_ack = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (mem_re === 1'b1 && ready === 1'b0) re_cycles++;
      if (c == 3) mem_ack = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (re_cycles != 3 || mem_re !== 1'b0 || ready !== 1'b1 || fault !== 1'b0 || data_mem !== 32'h1234_5678) begin
      errors++;
      $display("FAIL load_delayed got recyc=%0d re=%0b rdy=%0b flt=%0b d=%h exp 3 0 1 0 12345678",
               re_cycles, mem_re, ready, fault, data_mem);
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (data_mem !== 32'h1234_5678) begin errors++; $display("FAIL load_data_hold got %h exp 12345678", data_mem); end
  endtask

  task automatic test_illegal;
    logic [31:0] addrs [3] = '{32'd1026, 32'd1020, 32'd1280};
    for (int i = 0; i < 3; i++) begin
      MEM_R_EN = 1'b1; ALU_Res = addrs[i]; mem_rdata = 32'hFFFF_FFFF; mem_ack = 1'b0;
      #1;
      checks++;
      if (freeze !== 1'b1) begin errors++; $display("FAIL illegal_freeze_c0 addr=%0d got %0b exp 1", addrs[i], freeze); end
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || fault !== 1'b1 || data_mem !== 32'd0 || mem_re !== 1'b0 ||
          mem_we !== 1'b0 || freeze !== 1'b0) begin
        errors++;
        $display("FAIL illegal_done addr=%0d got rdy=%0b flt=%0b d=%h re=%0b we=%0b frz=%0b exp 1 1 0 0 0 0",
                 addrs[i], ready, fault, data_mem, mem_re, mem_we, freeze);
      end
      idle_inputs();
      @(negedge clk);
    end
  endtask

  task automatic test_timeout(input bit ack_last);
    int re_cycles = 0;
    int c = 0;
    MEM_R_EN = 1'b1; ALU_Res = 32'd1028; mem_rdata = 32'hA5A5_0F0F; mem_ack = 1'b0;
    do begin
      @(negedge clk);
      c++;
      if (mem_re === 1'b1) re_cycles++;
      if (ack_last && c == 15) mem_ack = 1'b1;
    end while (ready !== 1'b1 && c < 40);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_no_ready ack_last=%0b got no ready in %0d cycles exp ready at 16", ack_last, c);
    end else if (c != 16 || re_cycles != 15 || mem_re !== 1'b0 || fault !== !ack_last ||
                 data_mem !== (ack_last ? 32'hA5A5_0F0F : 32'd0)) begin
      errors++;
      $display("FAIL timeout ack_last=%0b got cyc=%0d recyc=%0d re=%0b flt=%0b d=%h exp 16 15 0 %0b %h",
               ack_last, c, re_cycles, mem_re, fault, data_mem, !ack_last,
               ack_last ? 32'hA5A5_0F0F : 32'd0);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    MEM_W_EN = 1'b1; MEM_R_EN = 1'b1; ALU_Res = 32'd1036; Val_Rm = 32'hCAFE_F00D;
    mem_rdata = 32'h0BAD_CAFE; mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 6'd3 || mem_wdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL b2b_write got we=%0b re=%0b a=%0d wd=%h exp 1 0 3 cafef00d", mem_we, mem_re, mem_addr, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || fault !== 1'b0 || data_mem !== 32'd0) begin
      errors++;
      $display("FAIL b2b_write_done got rdy=%0b flt=%0b d=%h exp 1 0 0", ready, fault, data_mem);
    end
    MEM_W_EN = 1'b0; ALU_Res = 32'd1040;
    @(negedge clk);
    checks++;
    if (mem_re !== 1'b0 || mem_we !== 1'b0 || ready !== 1'b0 || freeze !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle got re=%0b we=%0b rdy=%0b frz=%0b exp 0 0 0 1", mem_re, mem_we, ready, freeze);
    end
    @(negedge clk);
    checks++;
    if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 6'd4) begin
      errors++;
      $display("FAIL b2b_read got re=%0b we=%0b a=%0d exp 1 0 4", mem_re, mem_we, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || data_mem !== 32'h0BAD_CAFE) begin
      errors++;
      $display("FAIL b2b_read_done got rdy=%0b d=%h exp 1 0badcafe", ready, data_mem);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_busy;
    int seen_ready = 0;
    MEM_R_EN = 1'b1; ALU_Res = 32'd1024; mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_re !== 1'b1) begin errors++; $display("FAIL midrst_busy got re=%0b exp 1", mem_re); end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_re !== 1'b0 || mem_we !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async got re=%0b we=%0b rdy=%0b exp 0 0 0", mem_re, mem_we, ready);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ready === 1'b1) seen_ready++;
    end
    checks++;
    if (seen_ready != 0 || data_mem !== 32'd0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_ready got readys=%0d d=%h flt=%0b exp 0 0 0", seen_ready, data_mem, fault);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load_delayed();
    test_illegal();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_back_to_back();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
